rvx_core_decode_queue: RTL

Parametrised fetch-to-issue instruction buffer with integrated RV32I decode. It sits between the fetch unit and the execute stage. Each instruction is pre-decoded when it is enqueued, and the instruction plus its decoded fields are stored in a DEPTH-entry FIFO. Entries are presented in order at the issue side under a valid/ready handshake, and a flush empties the queue on branch redirect or trap.

---
 rtl/rvx_core_decode_queue_if.sv | 47 ++++
 rtl/rvx_core_decode_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rvx_core_decode_queue_if.sv
// Fetch-side and issue-side handshake bundle for rvx_core_decode_queue.
// Build macro RVX_DECODE_QUEUE_M_EXT_EN adds the issue_muldiv signal.
interface rvx_core_decode_queue_if #(
  parameter int XLEN = 32
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds valid and its payload until that edge, and ready never depends
  // combinationally on valid.
  logic            fetch_valid;
  logic            fetch_ready;
  logic [31:0]     fetch_instruction;
  logic [XLEN-1:0] fetch_pc;

  logic            issue_valid;
  logic            issue_ready;
  logic [31:0]     issue_instruction;
  logic [XLEN-1:0] issue_pc;
  logic [2:0]      issue_class;
  logic            issue_illegal;
  logic            issue_writes_rd;
  logic [4:0]      issue_rd;
  logic [4:0]      issue_rs1;
  logic [4:0]      issue_rs2;
`ifdef RVX_DECODE_QUEUE_M_EXT_EN
  logic            issue_muldiv;
`endif

  // Environment view: drives fetch and issue_ready.
  modport master (
    output fetch_valid, fetch_instruction, fetch_pc, issue_ready,
    input  fetch_ready, issue_valid, issue_instruction, issue_pc, issue_class,
           issue_illegal, issue_writes_rd, issue_rd, issue_rs1, issue_rs2
`ifdef RVX_DECODE_QUEUE_M_EXT_EN
   ,input  issue_muldiv
`endif
  );

  // Queue view.
  modport slave (
    input  fetch_valid, fetch_instruction, fetch_pc, issue_ready,
    output fetch_ready, issue_valid, issue_instruction, issue_pc, issue_class,
           issue_illegal, issue_writes_rd, issue_rd, issue_rs1, issue_rs2
`ifdef RVX_DECODE_QUEUE_M_EXT_EN
   ,output issue_muldiv
`endif
  );
endinterface

// File: rtl/rvx_core_decode_queue.sv
// Fetch-to-issue FIFO with RV32I pre-decode on enqueue, first-word-fall-through issue.
// Build macro RVX_DECODE_QUEUE_M_EXT_EN makes OP funct7=0000001 (M extension) legal.
module rvx_core_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  rvx_core_decode_queue_if.slave   q,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSN_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    CLS_ALU      = 3'd0,
    CLS_LOAD     = 3'd1,
    CLS_STORE    = 3'd2,
    CLS_BRANCH   = 3'd3,
    CLS_JUMP     = 3'd4,
    CLS_UPPER    = 3'd5,
    CLS_SYSTEM   = 3'd6,
    CLS_MISC_MEM = 3'd7
  } insn_class_e;

  typedef struct packed {
    insn_class_e cls;
    logic        illegal;
    logic        writes_rd;
    logic        muldiv;
  } dec_t;

  logic [PW-1:0] wptr, rptr;
  logic          empty, full, push, pop;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  dec_t            dec_mem   [DEPTH];

  dec_t        dec;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic        rd_writer;
  logic        is_muldiv;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

  assign q.fetch_ready = !full;
  assign q.issue_valid = !empty;
  assign push = q.fetch_valid & !full & !flush;
  assign pop  = !empty & q.issue_ready & !flush;
  assign occupancy = wptr - rptr;

  assign opcode = q.fetch_instruction[6:0];
  assign funct3 = q.fetch_instruction[14:12];
  assign funct7 = q.fetch_instruction[31:25];
  assign rd     = q.fetch_instruction[11:7];

  always_comb begin
    dec       = '0;
    dec.cls   = CLS_ALU;
    rd_writer = 1'b0;
    is_muldiv = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec.cls   = CLS_UPPER;
        rd_writer = 1'b1;
      end
      OPC_JAL: begin
        dec.cls   = CLS_JUMP;
        rd_writer = 1'b1;
      end
      OPC_JALR: begin
        dec.cls     = CLS_JUMP;
        rd_writer   = 1'b1;
        dec.illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.cls     = CLS_BRANCH;
        dec.illegal = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        dec.cls     = CLS_LOAD;
        rd_writer   = 1'b1;
        dec.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.cls     = CLS_STORE;
        dec.illegal = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        rd_writer = 1'b1;
        // Only the shift-immediates constrain the upper seven bits.
        case (funct3)
          3'b001:  dec.illegal = (funct7 != 7'b0000000);
          3'b101:  dec.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          default: dec.illegal = 1'b0;
        endcase
      end
      OPC_OP: begin
        rd_writer = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.illegal = 1'b0;
        end else if (funct7 == 7'b0100000) begin
          dec.illegal = (funct3 != 3'b000) && (funct3 != 3'b101);
`ifdef RVX_DECODE_QUEUE_M_EXT_EN
        end else if (funct7 == 7'b0000001) begin
          is_muldiv = 1'b1;
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OPC_MISC_MEM: dec.cls = CLS_MISC_MEM;
      OPC_SYSTEM: begin
        dec.cls = CLS_SYSTEM;
        // funct3 000 is the privileged group, 100 is unallocated; the rest are CSR ops.
        if ((funct3 != 3'b000) && (funct3 != 3'b100)) begin
          rd_writer = 1'b1;
        end else begin
          dec.illegal = (q.fetch_instruction != INSN_ECALL) &&
                        (q.fetch_instruction != INSN_EBREAK) &&
                        (q.fetch_instruction != INSN_MRET);
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.writes_rd = rd_writer && !dec.illegal && (rd != 5'd0);
    dec.muldiv    = is_muldiv && !dec.illegal;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Payload storage carries no reset; validity comes only from the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wptr[AW-1:0]] <= q.fetch_instruction;
      pc_mem[wptr[AW-1:0]]    <= q.fetch_pc;
      dec_mem[wptr[AW-1:0]]   <= dec;
    end
  end

  assign q.issue_instruction = instr_mem[rptr[AW-1:0]];
  assign q.issue_pc          = pc_mem[rptr[AW-1:0]];
  assign q.issue_class       = dec_mem[rptr[AW-1:0]].cls;
  assign q.issue_illegal     = dec_mem[rptr[AW-1:0]].illegal;
  assign q.issue_writes_rd   = dec_mem[rptr[AW-1:0]].writes_rd;
  assign q.issue_rd          = instr_mem[rptr[AW-1:0]][11:7];
  assign q.issue_rs1         = instr_mem[rptr[AW-1:0]][19:15];
  assign q.issue_rs2         = instr_mem[rptr[AW-1:0]][24:20];
`ifdef RVX_DECODE_QUEUE_M_EXT_EN
  assign q.issue_muldiv      = dec_mem[rptr[AW-1:0]].muldiv;
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{dec_mem[rptr[AW-1:0]].muldiv};
`endif
endmodule
